// File: rtl/sad_min_tracker_pkg.sv
// Shared types and defaults for the minimum-SAD tracker.
// Optional build macro used by the top: SAD_SATURATE_EN (saturating accumulator).
package sad_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int LANES_DEF = 4;
  localparam int SAD_W_DEF = 32;
  localparam int IDX_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CMP   = 2'd2
  } sad_state_e;

  // Width of one beat's lane sum: each lane contributes at most 2^PIX_W - 1.
  function automatic int lane_sum_w(input int pix_w, input int lanes);
    return pix_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/sad_min_tracker_if.sv
// Beat stream, load-min request and write-back result of the SAD tracker.
// master = pipeline / SAD datapath side, slave = the tracker itself.
interface sad_min_tracker_if
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int SAD_W = SAD_W_DEF
);

  logic                   start;
  logic                   beat_valid;
  logic [LANES*PIX_W-1:0] pix_a;
  logic [LANES*PIX_W-1:0] pix_b;
  logic                   beat_last;
  logic                   search_last;
  logic                   ld_min_req;
  logic                   ld_min_sel;
  logic [SAD_W-1:0]       SAD_WB_value;
  logic                   load_min_tag;
  logic                   sad_stall;
  logic                   busy;
  logic                   done;

  modport master (
    output start, beat_valid, pix_a, pix_b, beat_last, search_last,
           ld_min_req, ld_min_sel,
    input  SAD_WB_value, load_min_tag, sad_stall, busy, done
  );

  modport slave (
    input  start, beat_valid, pix_a, pix_b, beat_last, search_last,
           ld_min_req, ld_min_sel,
    output SAD_WB_value, load_min_tag, sad_stall, busy, done
  );

endinterface

// File: rtl/sad_min_tracker_abs_diff_tree.sv
// Combinational per-lane |a - b| followed by a binary adder tree.
// Lane count need not be a power of two; missing leaves are zero.
module sad_abs_diff_tree
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int SUM_W = lane_sum_w(PIX_W, LANES)
) (
  input  logic [LANES*PIX_W-1:0] pix_a,
  input  logic [LANES*PIX_W-1:0] pix_b,
  output logic [SUM_W-1:0]       lane_sum
);

  localparam int LEAVES = 1 << $clog2(LANES);

  logic [PIX_W-1:0] abs_diff [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] a_lane;
      logic [PIX_W-1:0] b_lane;
      assign a_lane = pix_a[gi*PIX_W +: PIX_W];
      assign b_lane = pix_b[gi*PIX_W +: PIX_W];
      // Unsigned pixels: subtract the smaller from the larger.
      assign abs_diff[gi] = (a_lane >= b_lane) ? (a_lane - b_lane) : (b_lane - a_lane);
    end
  endgenerate

  // Heap-ordered tree: leaves at [LEAVES, 2*LEAVES), node k = child 2k + child 2k+1.
  always_comb begin
    logic [SUM_W-1:0] node [1:2*LEAVES-1];
    node = '{default: '0};
    for (int k = 0; k < LANES; k++) begin
      node[LEAVES + k] = SUM_W'(abs_diff[k]);
    end
    for (int k = LEAVES - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k + 1];
    end
    lane_sum = node[1];
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Streaming SAD accumulator that keeps the smallest block SAD and its index
// and serves them to write-back on a load-min request.
// Build macro: SAD_SATURATE_EN -- accumulator saturates instead of wrapping.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int SAD_W = SAD_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input logic              Clk,
  input logic              Reset,
  sad_min_tracker_if.slave bus
);

  localparam int SUM_W = lane_sum_w(PIX_W, LANES);

  sad_state_e       state_q, state_d;
  logic [SAD_W-1:0] acc_q, acc_d;
  logic [SAD_W-1:0] min_q, min_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic [IDX_W-1:0] blk_q, blk_d;
  logic             search_last_q, search_last_d;
  logic [SAD_W-1:0] wb_value_q, wb_value_d;
  logic             load_min_tag_q, load_min_tag_d;
  logic             done_q, done_d;

  logic [SUM_W-1:0] lane_sum;
  logic [SAD_W-1:0] acc_add;
  logic [SAD_W-1:0] idx_ext;

  sad_abs_diff_tree #(
    .PIX_W (PIX_W),
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_tree (
    .pix_a    (bus.pix_a),
    .pix_b    (bus.pix_b),
    .lane_sum (lane_sum)
  );

`ifdef SAD_SATURATE_EN
  logic [SAD_W:0] acc_wide;
  // One extra bit catches the overflow; clamp to all ones when it is set.
  always_comb begin
    acc_wide = {1'b0, acc_q} + (SAD_W+1)'(lane_sum);
    acc_add  = acc_wide[SAD_W] ? {SAD_W{1'b1}} : acc_wide[SAD_W-1:0];
  end
`else
  // Modular accumulation: overflow simply wraps.
  always_comb begin
    acc_add = acc_q + SAD_W'(lane_sum);
  end
`endif

  assign idx_ext = SAD_W'(min_idx_q);

  // Next-state logic for the search FSM, the running minimum and the load-min port.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    min_d          = min_q;
    min_idx_d      = min_idx_q;
    blk_d          = blk_q;
    search_last_d  = search_last_q;
    wb_value_d     = '0;
    load_min_tag_d = 1'b0;
    done_d         = 1'b0;

    // Requests are only served from IDLE; a start in the same cycle still sees
    // the pre-start minimum because this reads the current registers.
    if (bus.ld_min_req && (state_q == ST_IDLE)) begin
      load_min_tag_d = 1'b1;
      wb_value_d     = bus.ld_min_sel ? idx_ext : min_q;
    end

    if (bus.start) begin
      // Start (or restart/abort) wipes every piece of search progress.
      state_d       = ST_ACCUM;
      acc_d         = '0;
      min_d         = {SAD_W{1'b1}};
      min_idx_d     = '0;
      blk_d         = '0;
      search_last_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ACCUM: begin
          if (bus.beat_valid) begin
            acc_d = acc_add;
            if (bus.beat_last) begin
              state_d       = ST_CMP;
              search_last_d = bus.search_last;
            end
          end
        end
        ST_CMP: begin
          // Strict compare: a tie keeps the earlier block.
          if (acc_q < min_q) begin
            min_d     = acc_q;
            min_idx_d = blk_q;
          end
          blk_d = blk_q + IDX_W'(1);
          acc_d = '0;
          if (search_last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All tracker state; asynchronous reset drops any search in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      min_q          <= {SAD_W{1'b1}};
      min_idx_q      <= '0;
      blk_q          <= '0;
      search_last_q  <= 1'b0;
      wb_value_q     <= '0;
      load_min_tag_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      min_q          <= min_d;
      min_idx_q      <= min_idx_d;
      blk_q          <= blk_d;
      search_last_q  <= search_last_d;
      wb_value_q     <= wb_value_d;
      load_min_tag_q <= load_min_tag_d;
      done_q         <= done_d;
    end
  end

  assign bus.SAD_WB_value = wb_value_q;
  assign bus.load_min_tag = load_min_tag_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.sad_stall    = bus.ld_min_req && (state_q != ST_IDLE);

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker: a table of single-block searches plus
// hand-written sequences for ties, stalls, resets, restarts and overflow.
module tb_sad_min_tracker;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sad;
  } vec_t;

  vec_t vecs [5];

  sad_min_tracker_if #(.PIX_W(8), .LANES(4), .SAD_W(32)) if0 ();
  sad_min_tracker_if #(.PIX_W(8), .LANES(4), .SAD_W(10)) if1 ();

  sad_min_tracker #(.PIX_W(8), .LANES(4), .SAD_W(32), .IDX_W(16)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if0)
  );

  sad_min_tracker #(.PIX_W(8), .LANES(4), .SAD_W(10), .IDX_W(8)) u_dut10 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if1)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.start = 0; if0.beat_valid = 0; if0.pix_a = '0; if0.pix_b = '0;
    if0.beat_last = 0; if0.search_last = 0; if0.ld_min_req = 0; if0.ld_min_sel = 0;
    if1.start = 0; if1.beat_valid = 0; if1.pix_a = '0; if1.pix_b = '0;
    if1.beat_last = 0; if1.search_last = 0; if1.ld_min_req = 0; if1.ld_min_sel = 0;
  endtask

  task automatic start_search();
    if0.start = 1;
    tick();
    if0.start = 0;
    $display("start search");
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last, input logic slast);
    if0.beat_valid = 1; if0.pix_a = a; if0.pix_b = b;
    if0.beat_last = last; if0.search_last = slast;
    tick();
    if0.beat_valid = 0; if0.beat_last = 0; if0.search_last = 0;
    $display("beat a=0x%08h b=0x%08h last=%0d search_last=%0d", a, b, last, slast);
  endtask

  task automatic load_min(input logic sel, input logic [31:0] exp, input string name);
    if0.ld_min_req = 1; if0.ld_min_sel = sel;
    #1;
    check({name, "_stall"}, 32'(if0.sad_stall), 32'd0);
    tick();
    if0.ld_min_req = 0;
    check({name, "_tag"}, 32'(if0.load_min_tag), 32'd1);
    check({name, "_value"}, if0.SAD_WB_value, exp);
    $display("load-min sel=%0d value=0x%0h tag=%0d", sel, if0.SAD_WB_value, if0.load_min_tag);
  endtask

  initial begin
    logic [31:0] exp10;
    // a={10,20,30,40}, b={12,15,30,50} -> 2+5+0+10
    vecs[0] = {32'h281E140A, 32'h321E0F0C, 32'd17};
    vecs[1] = {32'hFFFFFFFF, 32'h00000000, 32'd1020};
    vecs[2] = {32'h12345678, 32'h12345678, 32'd0};
    vecs[3] = {32'h00000000, 32'h04030201, 32'd10};
    // a={200,5,100,7}, b={100,50,100,9} -> 100+45+0+2
    vecs[4] = {32'h076405C8, 32'h09643264, 32'd147};

    idle_inputs();
    Reset = 1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_value", if0.SAD_WB_value, 32'd0);
    check("rst_tag", 32'(if0.load_min_tag), 32'd0);
    check("rst_done", 32'(if0.done), 32'd0);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_stall", 32'(if0.sad_stall), 32'd0);
    check("rst_busy10", 32'(if1.busy), 32'd0);
    @(negedge Clk);
    Reset = 0;
    tick();

    load_min(0, 32'hFFFFFFFF, "fresh_min");
    load_min(1, 32'd0, "fresh_idx");
    tick();
    check("tag_one_cycle", 32'(if0.load_min_tag), 32'd0);

    // Table: one single-beat block per search.
    for (int i = 0; i < 5; i++) begin
      start_search();
      beat(vecs[i].a, vecs[i].b, 1'b1, 1'b1);
      check($sformatf("vec%0d_cmp_busy", i), 32'(if0.busy), 32'd1);
      check($sformatf("vec%0d_cmp_done", i), 32'(if0.done), 32'd0);
      tick();
      check($sformatf("vec%0d_done", i), 32'(if0.done), 32'd1);
      check($sformatf("vec%0d_idle", i), 32'(if0.busy), 32'd0);
      load_min(0, vecs[i].exp_sad, $sformatf("vec%0d_min", i));
      load_min(1, 32'd0, $sformatf("vec%0d_idx", i));
    end

    // Blocks 100 (two beats), 40, 40; a beat in the CMP cycle is dropped.
    start_search();
    beat(32'h32, 32'h0, 1'b0, 1'b0);
    beat(32'h32, 32'h0, 1'b1, 1'b0);
    beat(32'hFF, 32'h0, 1'b0, 1'b0);
    beat(32'h28, 32'h0, 1'b1, 1'b0);
    tick();
    beat(32'h28, 32'h0, 1'b1, 1'b1);
    tick();
    check("tie_done", 32'(if0.done), 32'd1);
    tick();
    check("tie_done_pulse", 32'(if0.done), 32'd0);
    load_min(0, 32'd40, "tie_min");
    load_min(1, 32'd1, "tie_idx");

    // Load-min held through a search: stalled until IDLE, served after.
    start_search();
    if0.ld_min_req = 1; if0.ld_min_sel = 0;
    #1;
    check("hold_stall_accum", 32'(if0.sad_stall), 32'd1);
    beat(vecs[0].a, vecs[0].b, 1'b1, 1'b1);
    check("hold_stall_cmp", 32'(if0.sad_stall), 32'd1);
    check("hold_tag_cmp", 32'(if0.load_min_tag), 32'd0);
    tick();
    check("hold_stall_idle", 32'(if0.sad_stall), 32'd0);
    check("hold_tag_idle", 32'(if0.load_min_tag), 32'd0);
    tick();
    if0.ld_min_req = 0;
    check("hold_tag", 32'(if0.load_min_tag), 32'd1);
    check("hold_value", if0.SAD_WB_value, 32'd17);
    $display("load-min after stall value=0x%0h", if0.SAD_WB_value);
    tick();

    // start + ld_min_req together: served with the pre-start minimum.
    if0.start = 1; if0.ld_min_req = 1; if0.ld_min_sel = 0;
    tick();
    if0.start = 0; if0.ld_min_req = 0;
    check("same_cycle_tag", 32'(if0.load_min_tag), 32'd1);
    check("same_cycle_value", if0.SAD_WB_value, 32'd17);
    check("same_cycle_busy", 32'(if0.busy), 32'd1);
    $display("load-min with start value=0x%0h", if0.SAD_WB_value);
    // Asynchronous reset while the result is still on the port.
    Reset = 1;
    #2;
    check("async_rst_tag", 32'(if0.load_min_tag), 32'd0);
    check("async_rst_value", if0.SAD_WB_value, 32'd0);
    check("async_rst_busy", 32'(if0.busy), 32'd0);
    @(negedge Clk);
    Reset = 0;
    tick();

    // Reset after two beats discards the search.
    start_search();
    beat(vecs[0].a, vecs[0].b, 1'b0, 1'b0);
    beat(vecs[0].a, vecs[0].b, 1'b0, 1'b0);
    Reset = 1;
    #2;
    check("mid_rst_busy", 32'(if0.busy), 32'd0);
    check("mid_rst_done", 32'(if0.done), 32'd0);
    @(negedge Clk);
    Reset = 0;
    tick();
    check("mid_rst_idle", 32'(if0.busy), 32'd0);
    load_min(0, 32'hFFFFFFFF, "mid_rst_min");
    load_min(1, 32'd0, "mid_rst_idx");

    // Restart mid-search: blocks 100, 120, partial 5, then restart with 150.
    start_search();
    beat(32'h64, 32'h0, 1'b1, 1'b0);
    tick();
    beat(32'h78, 32'h0, 1'b1, 1'b0);
    tick();
    beat(32'h05, 32'h0, 1'b0, 1'b0);
    start_search();
    beat(32'h96, 32'h0, 1'b1, 1'b1);
    tick();
    check("restart_done", 32'(if0.done), 32'd1);
    load_min(0, 32'd150, "restart_min");
    load_min(1, 32'd0, "restart_idx");

    // Narrow instance: 1020 + 80 = 1100 overflows a 10-bit accumulator.
`ifdef SAD_SATURATE_EN
    exp10 = 32'd1023;
`else
    exp10 = 32'd76;
`endif
    if1.start = 1;
    tick();
    if1.start = 0;
    if1.beat_valid = 1; if1.pix_a = 32'hFFFFFFFF; if1.pix_b = '0;
    tick();
    if1.pix_a = 32'h50; if1.beat_last = 1; if1.search_last = 1;
    tick();
    if1.beat_valid = 0; if1.beat_last = 0; if1.search_last = 0;
    tick();
    check("w10_done", 32'(if1.done), 32'd1);
    if1.ld_min_req = 1; if1.ld_min_sel = 0;
    tick();
    check("w10_tag", 32'(if1.load_min_tag), 32'd1);
    check("w10_min", 32'(if1.SAD_WB_value), exp10);
    $display("narrow load-min sel=0 value=%0d", if1.SAD_WB_value);
    if1.ld_min_sel = 1;
    tick();
    if1.ld_min_req = 0;
    check("w10_idx", 32'(if1.SAD_WB_value), 32'd0);
    $display("narrow load-min sel=1 value=%0d", if1.SAD_WB_value);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
